// File: rtl/vmem_pkg.sv
// Shared definitions for the local vector memory request path:
// op field bit positions, address patterns and the sequencer state encoding.
package vmem_pkg;

  localparam int OP_WIDTH     = 7;
  // req_op = {memop, pattern[1:0], size[1:0], signed, we}
  localparam int OP_MEMOP     = 6;
  localparam int OP_PAT_HI    = 5;
  localparam int OP_PAT_LO    = 4;
  localparam int OP_PAT_INDEX = 5;
  localparam int OP_WE        = 0;

  localparam logic [1:0] OP_PAT_UNIT   = 2'b00;
  localparam logic [1:0] OP_PAT_STRIDE = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_DRAIN = 2'b10,
    ST_FIN   = 2'b11
  } vmem_state_e;

  // Stores carry write data and indexed ops carry offsets, so both consume the beat stream.
  function automatic logic needs_bt_stream(input logic [OP_WIDTH-1:0] op);
    return op[OP_WE] | op[OP_PAT_INDEX];
  endfunction

endpackage

// File: rtl/vmem_ld_tag_pipe.sv
// Delay line that carries the {valid, lane mask, last} tag of each issued load
// beat alongside the memory read latency, so the tag lines up with mem_out.
module vmem_ld_tag_pipe #(
  parameter int NUMLANES = 8,
  parameter int DEPTH    = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [NUMLANES-1:0] in_mask,
  input  logic                in_last,
  output logic                out_valid,
  output logic [NUMLANES-1:0] out_mask,
  output logic                out_last
);

  logic [DEPTH-1:0]               valid_r;
  logic [DEPTH-1:0][NUMLANES-1:0] mask_r;
  logic [DEPTH-1:0]               last_r;

  // Shift the tag one stage per cycle; reset drops everything in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r <= '0;
      mask_r  <= '0;
      last_r  <= '0;
    end else begin
      valid_r[0] <= in_valid;
      mask_r[0]  <= in_mask;
      last_r[0]  <= in_last;
      for (int i = 1; i < DEPTH; i++) begin
        valid_r[i] <= valid_r[i-1];
        mask_r[i]  <= mask_r[i-1];
        last_r[i]  <= last_r[i-1];
      end
    end
  end

  assign out_valid = valid_r[DEPTH-1];
  assign out_mask  = mask_r[DEPTH-1];
  assign out_last  = last_r[DEPTH-1];

endmodule

// File: rtl/vmem_local_seq.sv
// Request sequencer in front of port A of the per-lane local vector memory.
// Splits one vector load/store into NUMLANES-wide beats, steps the base
// address per beat and tags returning load data with a lane mask and last flag.
module vmem_local_seq
  import vmem_pkg::*;
#(
  parameter int NUMLANES     = 8,
  parameter int DATAWORDSIZE = 16,
  parameter int VCWIDTH      = 32,
  parameter int MEMDEPTH     = 2048,
  parameter int LOGMEMDEPTH  = $clog2(MEMDEPTH),
  parameter int VLWIDTH      = 8,
  parameter int MEM_LAT      = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [OP_WIDTH-1:0]              req_op,
  input  logic [LOGMEMDEPTH-1:0]           req_base,
  input  logic [VCWIDTH-1:0]               req_stride,
  input  logic [VLWIDTH-1:0]               req_vl,
  input  logic                             bt_valid,
  output logic                             bt_ready,
  input  logic [NUMLANES*DATAWORDSIZE-1:0] bt_data,
  input  logic [NUMLANES*16-1:0]           bt_offset,
  output logic                             mem_en,
  output logic [OP_WIDTH-1:0]              mem_op,
  output logic [LOGMEMDEPTH-1:0]           mem_address,
  output logic [VCWIDTH-1:0]               mem_stride,
  output logic [NUMLANES*16-1:0]           mem_offset,
  output logic [NUMLANES*DATAWORDSIZE-1:0] mem_data,
  input  logic [NUMLANES*DATAWORDSIZE-1:0] mem_out,
  output logic                             ld_valid,
  output logic [NUMLANES*DATAWORDSIZE-1:0] ld_data,
  output logic [NUMLANES-1:0]              ld_mask,
  output logic                             ld_last,
  output logic                             done,
  output logic                             err
);

  localparam int LANE_SHIFT = $clog2(NUMLANES);

  vmem_state_e              state_r;
  logic [OP_WIDTH-1:0]      op_r;
  logic [LOGMEMDEPTH-1:0]   addr_r;
  logic [VCWIDTH-1:0]       stride_r;
  logic [VLWIDTH-1:0]       rem_r;
  logic [VLWIDTH-1:0]       beats_r;
  logic                     req_ready_r;
  logic                     done_r;
  logic                     err_r;

  logic                     needs_bt_s;
  logic                     fire_s;
  logic                     last_beat_s;
  logic [LOGMEMDEPTH-1:0]   step_s;
  logic [NUMLANES-1:0]      mask_s;
  logic [VLWIDTH:0]         beats_calc_s;
  logic                     pipe_valid_s;
  logic [NUMLANES-1:0]      pipe_mask_s;
  logic                     pipe_last_s;

  // Beat qualification, per-beat address step and live-lane mask.
  always_comb begin
    needs_bt_s   = needs_bt_stream(op_r);
    fire_s       = (state_r == ST_ISSUE) && (!needs_bt_s || bt_valid);
    last_beat_s  = (beats_r == VLWIDTH'(1));
    beats_calc_s = ({1'b0, req_vl} + (VLWIDTH+1)'(NUMLANES - 1)) >> LANE_SHIFT;
    case (op_r[OP_PAT_HI:OP_PAT_LO])
      OP_PAT_UNIT:   step_s = LOGMEMDEPTH'(NUMLANES);
      OP_PAT_STRIDE: step_s = LOGMEMDEPTH'(stride_r << LANE_SHIFT);
      default:       step_s = '0;
    endcase
    mask_s = '0;
    for (int i = 0; i < NUMLANES; i++) begin
      mask_s[i] = (i < int'(rem_r));
    end
  end

  // Sequencer FSM: accept, issue beats, wait for the last load tag, pulse done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      op_r        <= '0;
      addr_r      <= '0;
      stride_r    <= '0;
      rem_r       <= '0;
      beats_r     <= '0;
      req_ready_r <= 1'b1;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            op_r     <= req_op;
            addr_r   <= req_base;
            stride_r <= req_stride;
            rem_r    <= req_vl;
            beats_r  <= VLWIDTH'(beats_calc_s);
            if ((req_vl == '0) || !req_op[OP_MEMOP]) begin
              state_r     <= ST_FIN;
              done_r      <= 1'b1;
              req_ready_r <= 1'b0;
            end else if (req_op[OP_WE] && (req_vl[LANE_SHIFT-1:0] != '0)) begin
              // Port A cannot mask lanes on write, so partial store beats are refused.
              err_r <= 1'b1;
            end else begin
              state_r     <= ST_ISSUE;
              req_ready_r <= 1'b0;
            end
          end
        end
        ST_ISSUE: begin
          if (fire_s) begin
            rem_r   <= (rem_r > VLWIDTH'(NUMLANES)) ? (rem_r - VLWIDTH'(NUMLANES)) : '0;
            beats_r <= beats_r - VLWIDTH'(1);
            addr_r  <= addr_r + step_s;
            if (last_beat_s) begin
              if (op_r[OP_WE]) begin
                state_r <= ST_FIN;
                done_r  <= 1'b1;
              end else begin
                state_r <= ST_DRAIN;
              end
            end
          end
        end
        ST_DRAIN: begin
          if (pipe_valid_s && pipe_last_s) begin
            state_r <= ST_FIN;
            done_r  <= 1'b1;
          end
        end
        ST_FIN: begin
          state_r     <= ST_IDLE;
          req_ready_r <= 1'b1;
        end
        default: begin
          state_r     <= ST_IDLE;
          req_ready_r <= 1'b1;
        end
      endcase
    end
  end

  vmem_ld_tag_pipe #(
    .NUMLANES (NUMLANES),
    .DEPTH    (MEM_LAT)
  ) u_ld_tag_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (fire_s & ~op_r[OP_WE]),
    .in_mask   (mask_s),
    .in_last   (last_beat_s),
    .out_valid (pipe_valid_s),
    .out_mask  (pipe_mask_s),
    .out_last  (pipe_last_s)
  );

  assign req_ready   = req_ready_r;
  assign done        = done_r;
  assign err         = err_r;
  assign mem_en      = fire_s;
  assign bt_ready    = fire_s & needs_bt_s;
  assign mem_op      = op_r;
  assign mem_address = addr_r;
  assign mem_stride  = stride_r;
  // Beat payload is only presented while issuing so idle/reset outputs stay quiet.
  assign mem_data    = (state_r == ST_ISSUE) ? bt_data : '0;
  assign mem_offset  = (state_r == ST_ISSUE) ? bt_offset : '0;
  assign ld_valid    = pipe_valid_s;
  assign ld_mask     = pipe_mask_s;
  assign ld_last     = pipe_last_s;
  assign ld_data     = pipe_valid_s ? mem_out : '0;

endmodule

// File: tb/tb_vmem_local_seq.sv
// Directed bench for vmem_local_seq (NUMLANES=8, MEM_LAT=1).
module tb_vmem_local_seq;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic [6:0]   req_op;
  logic [10:0]  req_base;
  logic [31:0]  req_stride;
  logic [7:0]   req_vl;
  logic         bt_valid;
  logic         bt_ready;
  logic [127:0] bt_data;
  logic [127:0] bt_offset;
  logic         mem_en;
  logic [6:0]   mem_op;
  logic [10:0]  mem_address;
  logic [31:0]  mem_stride;
  logic [127:0] mem_offset;
  logic [127:0] mem_data;
  logic [127:0] mem_out;
  logic         ld_valid;
  logic [127:0] ld_data;
  logic [7:0]   ld_mask;
  logic         ld_last;
  logic         done;
  logic         err;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0]   OP_LD_UNIT   = 7'h44;
  localparam logic [6:0]   OP_ST_STRIDE = 7'h55;
  localparam logic [6:0]   OP_LD_INDEX  = 7'h64;
  localparam logic [6:0]   OP_ST_UNIT   = 7'h45;
  localparam logic [127:0] RD_PAT  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] ST_D1   = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] ST_D2   = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000;
  localparam logic [127:0] IDX_OFF = {16'd28, 16'd24, 16'd20, 16'd16, 16'd12, 16'd8, 16'd4, 16'd0};

  vmem_local_seq dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_base    (req_base),
    .req_stride  (req_stride),
    .req_vl      (req_vl),
    .bt_valid    (bt_valid),
    .bt_ready    (bt_ready),
    .bt_data     (bt_data),
    .bt_offset   (bt_offset),
    .mem_en      (mem_en),
    .mem_op      (mem_op),
    .mem_address (mem_address),
    .mem_stride  (mem_stride),
    .mem_offset  (mem_offset),
    .mem_data    (mem_data),
    .mem_out     (mem_out),
    .ld_valid    (ld_valid),
    .ld_data     (ld_data),
    .ld_mask     (ld_mask),
    .ld_last     (ld_last),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic issue_req(input logic [6:0] op, input logic [10:0] base,
                           input logic [31:0] stride, input logic [7:0] vl);
    cyc();
    req_valid  = 1'b1;
    req_op     = op;
    req_base   = base;
    req_stride = stride;
    req_vl     = vl;
    smp();
    chk("req_ready_at_accept", req_ready, 1'b1);
    cyc();
    req_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_op     = '0;
    req_base   = '0;
    req_stride = '0;
    req_vl     = '0;
    bt_valid   = 1'b0;
    bt_data    = '0;
    bt_offset  = '0;
    mem_out    = RD_PAT;

    // Reset state
    repeat (2) smp();
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_mem_addr", mem_address, 11'd0);
    chk("rst_ld_valid", ld_valid, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    cyc();
    reset = 1'b0;

    // Unit load, base 5, vl 20: addresses 5,13,21, masks FF,FF,0F
    issue_req(OP_LD_UNIT, 11'd5, 32'd0, 8'd20);
    smp();
    chk("ul_b0_en", mem_en, 1'b1);
    chk("ul_b0_addr", mem_address, 11'd5);
    chk("ul_b0_ready", req_ready, 1'b0);
    chk("ul_b0_ldv", ld_valid, 1'b0);
    cyc(); smp();
    chk("ul_b1_en", mem_en, 1'b1);
    chk("ul_b1_addr", mem_address, 11'd13);
    chk("ul_r0_ldv", ld_valid, 1'b1);
    chk("ul_r0_mask", ld_mask, 8'hFF);
    chk("ul_r0_last", ld_last, 1'b0);
    chk("ul_r0_data", ld_data, RD_PAT);
    cyc(); smp();
    chk("ul_b2_addr", mem_address, 11'd21);
    chk("ul_r1_mask", ld_mask, 8'hFF);
    cyc(); smp();
    chk("ul_drain_en", mem_en, 1'b0);
    chk("ul_r2_ldv", ld_valid, 1'b1);
    chk("ul_r2_mask", ld_mask, 8'h0F);
    chk("ul_r2_last", ld_last, 1'b1);
    chk("ul_r2_done", done, 1'b0);
    cyc(); smp();
    chk("ul_done", done, 1'b1);
    chk("ul_fin_ready", req_ready, 1'b0);
    chk("ul_fin_ldv", ld_valid, 1'b0);
    cyc(); smp();
    chk("ul_done_clr", done, 1'b0);
    chk("ul_idle_ready", req_ready, 1'b1);

    // Strided store, stride 3, vl 16, two-cycle bt stall after first beat
    bt_valid = 1'b1;
    bt_data  = ST_D1;
    issue_req(OP_ST_STRIDE, 11'd0, 32'd3, 8'd16);
    smp();
    chk("ss_b0_en", mem_en, 1'b1);
    chk("ss_b0_btr", bt_ready, 1'b1);
    chk("ss_b0_addr", mem_address, 11'd0);
    chk("ss_b0_data", mem_data, ST_D1);
    cyc();
    bt_valid = 1'b0;
    smp();
    chk("ss_st0_en", mem_en, 1'b0);
    chk("ss_st0_btr", bt_ready, 1'b0);
    chk("ss_st0_addr", mem_address, 11'd24);
    cyc(); smp();
    chk("ss_st1_en", mem_en, 1'b0);
    chk("ss_st1_addr", mem_address, 11'd24);
    cyc();
    bt_valid = 1'b1;
    bt_data  = ST_D2;
    smp();
    chk("ss_b1_en", mem_en, 1'b1);
    chk("ss_b1_btr", bt_ready, 1'b1);
    chk("ss_b1_addr", mem_address, 11'd24);
    chk("ss_b1_data", mem_data, ST_D2);
    chk("ss_stride", mem_stride, 32'd3);
    chk("ss_op", mem_op, OP_ST_STRIDE);
    cyc();
    bt_valid = 1'b0;
    smp();
    chk("ss_done", done, 1'b1);
    chk("ss_fin_en", mem_en, 1'b0);
    chk("ss_no_ldv", ld_valid, 1'b0);
    cyc();

    // Indexed load, base 100, vl 8, offsets 4*i
    bt_valid  = 1'b1;
    bt_offset = IDX_OFF;
    issue_req(OP_LD_INDEX, 11'd100, 32'd0, 8'd8);
    smp();
    chk("ix_en", mem_en, 1'b1);
    chk("ix_btr", bt_ready, 1'b1);
    chk("ix_addr", mem_address, 11'd100);
    chk("ix_offset", mem_offset, IDX_OFF);
    cyc();
    bt_valid = 1'b0;
    smp();
    chk("ix_addr_hold", mem_address, 11'd100);
    chk("ix_ldv", ld_valid, 1'b1);
    chk("ix_mask", ld_mask, 8'hFF);
    chk("ix_last", ld_last, 1'b1);
    cyc(); smp();
    chk("ix_done", done, 1'b1);
    cyc();

    // Store with vl 10 is rejected
    issue_req(OP_ST_UNIT, 11'd0, 32'd0, 8'd10);
    smp();
    chk("er_err", err, 1'b1);
    chk("er_en", mem_en, 1'b0);
    chk("er_ready", req_ready, 1'b1);
    chk("er_done", done, 1'b0);
    cyc(); smp();
    chk("er_err_clr", err, 1'b0);
    chk("er_en2", mem_en, 1'b0);

    // Load with vl 0 completes immediately
    issue_req(OP_LD_UNIT, 11'd7, 32'd0, 8'd0);
    smp();
    chk("z_done", done, 1'b1);
    chk("z_en", mem_en, 1'b0);
    cyc(); smp();
    chk("z_done_clr", done, 1'b0);
    chk("z_ldv", ld_valid, 1'b0);
    chk("z_ready", req_ready, 1'b1);

    // Address wrap: base 2044 unit load vl 16
    issue_req(OP_LD_UNIT, 11'd2044, 32'd0, 8'd16);
    smp();
    chk("wr_b0_addr", mem_address, 11'd2044);
    cyc(); smp();
    chk("wr_b1_en", mem_en, 1'b1);
    chk("wr_b1_addr", mem_address, 11'd4);
    cyc(); smp();
    chk("wr_last", ld_last, 1'b1);
    cyc(); smp();
    chk("wr_done", done, 1'b1);
    cyc();

    // Reset during the second beat of a load
    issue_req(OP_LD_UNIT, 11'd0, 32'd0, 8'd24);
    cyc(); smp();
    chk("ra_b1_en", mem_en, 1'b1);
    chk("ra_b1_addr", mem_address, 11'd8);
    reset = 1'b1;
    #1;
    chk("ra_en", mem_en, 1'b0);
    chk("ra_ready", req_ready, 1'b1);
    chk("ra_ldv", ld_valid, 1'b0);
    chk("ra_addr", mem_address, 11'd0);
    chk("ra_op", mem_op, 7'd0);
    chk("ra_done", done, 1'b0);
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      smp();
      chk("ra_post_done", done, 1'b0);
      chk("ra_post_ldv", ld_valid, 1'b0);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
